// File: rtl/m2vside4_if.sv
// Pixel stream in / frame-buffer write bus out for the stage-4 side-info block.
// master = pixel producer and write consumer; slave = m2vside4.
interface m2vside4_if #(
    parameter int PIX_WIDTH = 8,
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
);
    logic                   pix_valid;
    logic [PIX_WIDTH-1:0]   pix_data;
    logic                   wr_valid;
    logic [1:0]             wr_plane;
    logic [MBX_WIDTH+3:0]   wr_x;
    logic [MBY_WIDTH+3:0]   wr_y;
    logic [PIX_WIDTH-1:0]   wr_data;
    logic                   block_done;

    modport master (
        output pix_valid, pix_data,
        input  wr_valid, wr_plane, wr_x, wr_y, wr_data, block_done
    );

    modport slave (
        input  pix_valid, pix_data,
        output wr_valid, wr_plane, wr_x, wr_y, wr_data, block_done
    );
endinterface

// File: rtl/m2vside4.sv
// Stage-4 side info: latches stage-3 block info on block_start and turns the
// 64 reconstructed pixels of that block into registered frame-buffer writes.
module m2vside4 #(
    parameter int MVH_WIDTH = 16,
    parameter int MVV_WIDTH = 15,
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5,
    parameter int PIX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MVH_WIDTH-1:0] s3_mv_h,
    input  logic [MVV_WIDTH-1:0] s3_mv_v,
    input  logic [MBX_WIDTH-1:0] s3_mb_x,
    input  logic [MBY_WIDTH-1:0] s3_mb_y,
    input  logic                 s3_mb_intra,
    input  logic [2:0]           s3_block,
    input  logic                 s3_coded,
    input  logic                 s3_enable,
    input  logic                 block_start,
    m2vside4_if.slave            bus,
    output logic [MVH_WIDTH-1:0] s4_mv_h,
    output logic [MVV_WIDTH-1:0] s4_mv_v,
    output logic [MBX_WIDTH-1:0] s4_mb_x,
    output logic [MBY_WIDTH-1:0] s4_mb_y,
    output logic                 s4_mb_intra,
    output logic [2:0]           s4_block,
    output logic                 s4_coded,
    output logic                 s4_enable,
    output logic                 busy,
    output logic                 err
);
    localparam int XW = MBX_WIDTH + 4;
    localparam int YW = MBY_WIDTH + 4;

    logic [MVH_WIDTH-1:0] r_mv_h;
    logic [MVV_WIDTH-1:0] r_mv_v;
    logic [MBX_WIDTH-1:0] r_mb_x;
    logic [MBY_WIDTH-1:0] r_mb_y;
    logic                 r_mb_intra;
    logic [2:0]           r_block;
    logic                 r_coded;
    logic                 r_enable;
    logic [5:0]           r_cnt;
    logic                 r_busy;
    logic                 r_err;
    logic                 r_wr_valid;
    logic [1:0]           r_wr_plane;
    logic [XW-1:0]        r_wr_x;
    logic [YW-1:0]        r_wr_y;
    logic [PIX_WIDTH-1:0] r_wr_data;
    logic                 r_block_done;

    logic [2:0]           w_col;
    logic [2:0]           w_row;
    logic [1:0]           w_plane;
    logic [XW-1:0]        w_x;
    logic [YW-1:0]        w_y;
    logic                 w_blk_ok;

    assign w_col    = r_cnt[2:0];
    assign w_row    = r_cnt[5:3];
    assign w_blk_ok = (s3_block <= 3'd5);

    // Plane and absolute coordinate of the next pixel; macroblock origins are
    // multiples of 16 (luma) or 8 (chroma), so concatenation replaces the adds.
    always_comb begin
        w_plane = 2'd0;
        w_x     = '0;
        w_y     = '0;
        case (r_block)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                w_plane = 2'd0;
                w_x     = {r_mb_x, r_block[0], w_col};
                w_y     = {r_mb_y, r_block[1], w_row};
            end
            3'd4: begin
                w_plane = 2'd1;
                w_x     = {1'b0, r_mb_x, w_col};
                w_y     = {1'b0, r_mb_y, w_row};
            end
            3'd5: begin
                w_plane = 2'd2;
                w_x     = {1'b0, r_mb_x, w_col};
                w_y     = {1'b0, r_mb_y, w_row};
            end
            default: begin
                w_plane = 2'd0;
                w_x     = '0;
                w_y     = '0;
            end
        endcase
    end

    // Side-info latch, pixel counter, busy/err state and registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mv_h       <= '0;
            r_mv_v       <= '0;
            r_mb_x       <= '0;
            r_mb_y       <= '0;
            r_mb_intra   <= 1'b0;
            r_block      <= 3'd0;
            r_coded      <= 1'b0;
            r_enable     <= 1'b0;
            r_cnt        <= 6'd0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_plane   <= 2'd0;
            r_wr_x       <= '0;
            r_wr_y       <= '0;
            r_wr_data    <= '0;
            r_block_done <= 1'b0;
        end else begin
            r_wr_valid   <= 1'b0;
            r_block_done <= 1'b0;
            if (block_start) begin
                r_mv_h     <= s3_mv_h;
                r_mv_v     <= s3_mv_v;
                r_mb_x     <= s3_mb_x;
                r_mb_y     <= s3_mb_y;
                r_mb_intra <= s3_mb_intra;
                r_block    <= s3_block;
                r_coded    <= s3_coded;
                r_enable   <= s3_enable;
                r_cnt      <= 6'd0;
                r_busy     <= s3_enable & w_blk_ok;
                // A pixel arriving with block_start is dropped, never written.
                if (r_busy | bus.pix_valid | (s3_enable & ~w_blk_ok)) begin
                    r_err <= 1'b1;
                end
            end else if (bus.pix_valid) begin
                if (r_busy) begin
                    r_wr_valid <= 1'b1;
                    r_wr_plane <= w_plane;
                    r_wr_x     <= w_x;
                    r_wr_y     <= w_y;
                    r_wr_data  <= bus.pix_data;
                    r_cnt      <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) begin
                        r_busy       <= 1'b0;
                        r_block_done <= 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign s4_mv_h        = r_mv_h;
    assign s4_mv_v        = r_mv_v;
    assign s4_mb_x        = r_mb_x;
    assign s4_mb_y        = r_mb_y;
    assign s4_mb_intra    = r_mb_intra;
    assign s4_block       = r_block;
    assign s4_coded       = r_coded;
    assign s4_enable      = r_enable;
    assign busy           = r_busy;
    assign err            = r_err;
    assign bus.wr_valid   = r_wr_valid;
    assign bus.wr_plane   = r_wr_plane;
    assign bus.wr_x       = r_wr_x;
    assign bus.wr_y       = r_wr_y;
    assign bus.wr_data    = r_wr_data;
    assign bus.block_done = r_block_done;
endmodule

// File: tb/tb_m2vside4.sv
// Self-checking bench for m2vside4: table of block geometries, hand-written
// protocol-error sequences and a randomized run against a reference model.
module tb_m2vside4;
    localparam int MVH = 16;
    localparam int MVV = 15;
    localparam int MBX = 6;
    localparam int MBY = 5;
    localparam int PIX = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [MVH-1:0] s3_mv_h = '0;
    logic [MVV-1:0] s3_mv_v = '0;
    logic [MBX-1:0] s3_mb_x = '0;
    logic [MBY-1:0] s3_mb_y = '0;
    logic           s3_mb_intra = 1'b0;
    logic [2:0]     s3_block = 3'd0;
    logic           s3_coded = 1'b0;
    logic           s3_enable = 1'b0;
    logic           block_start = 1'b0;
    logic [MVH-1:0] s4_mv_h;
    logic [MVV-1:0] s4_mv_v;
    logic [MBX-1:0] s4_mb_x;
    logic [MBY-1:0] s4_mb_y;
    logic           s4_mb_intra;
    logic [2:0]     s4_block;
    logic           s4_coded;
    logic           s4_enable;
    logic           busy;
    logic           err;

    m2vside4_if #(.PIX_WIDTH(PIX), .MBX_WIDTH(MBX), .MBY_WIDTH(MBY)) bus ();

    m2vside4 #(
        .MVH_WIDTH(MVH), .MVV_WIDTH(MVV), .MBX_WIDTH(MBX),
        .MBY_WIDTH(MBY), .PIX_WIDTH(PIX)
    ) dut (
        .clk(clk), .reset(reset),
        .s3_mv_h(s3_mv_h), .s3_mv_v(s3_mv_v), .s3_mb_x(s3_mb_x), .s3_mb_y(s3_mb_y),
        .s3_mb_intra(s3_mb_intra), .s3_block(s3_block), .s3_coded(s3_coded),
        .s3_enable(s3_enable), .block_start(block_start), .bus(bus.slave),
        .s4_mv_h(s4_mv_h), .s4_mv_v(s4_mv_v), .s4_mb_x(s4_mb_x), .s4_mb_y(s4_mb_y),
        .s4_mb_intra(s4_mb_intra), .s4_block(s4_block), .s4_coded(s4_coded),
        .s4_enable(s4_enable), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int n_writes = 0;

    // Reference model state
    bit          m_busy, m_err, e_wv, e_done;
    int          m_cnt, m_blk, m_mbx, m_mby;
    int          e_plane, e_x, e_y, e_data;
    logic [47:0] m_s4;

    typedef struct {
        int mbx, mby, blk, plane, x0, y0, x63, y63, gmin, gmax;
    } vec_t;
    vec_t vecs[7];

    function automatic int ref_plane(int blk);
        return (blk < 4) ? 0 : blk - 3;
    endfunction
    function automatic int ref_x(int blk, int mbx, int k);
        return (blk < 4) ? mbx * 16 + (blk % 2) * 8 + k % 8 : mbx * 8 + k % 8;
    endfunction
    function automatic int ref_y(int blk, int mby, int k);
        return (blk < 4) ? mby * 16 + (blk / 2) * 8 + k / 8 : mby * 8 + k / 8;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_s3(input int mbx, input int mby, input int blk, input bit en);
        s3_mv_h     = 16'($urandom);
        s3_mv_v     = 15'($urandom);
        s3_mb_x     = 6'(mbx);
        s3_mb_y     = 5'(mby);
        s3_mb_intra = 1'($urandom);
        s3_block    = 3'(blk);
        s3_coded    = 1'($urandom);
        s3_enable   = en;
    endtask

    task automatic check_outputs();
        chk("wr_valid", longint'(bus.wr_valid), longint'(e_wv));
        chk("block_done", longint'(bus.block_done), longint'(e_done));
        chk("busy", longint'(busy), longint'(m_busy));
        chk("err", longint'(err), longint'(m_err));
        chk("wr_plane", longint'(bus.wr_plane), longint'(e_plane));
        chk("wr_x", longint'(bus.wr_x), longint'(e_x));
        chk("wr_y", longint'(bus.wr_y), longint'(e_y));
        chk("wr_data", longint'(bus.wr_data), longint'(e_data));
        chk("s4", longint'({s4_mv_h, s4_mv_v, s4_mb_x, s4_mb_y, s4_mb_intra,
                            s4_block, s4_coded, s4_enable}), longint'(m_s4));
    endtask

    // One clock: drive inputs, predict the DUT response, compare after the edge.
    task automatic step(input bit bs, input bit pv, input int pd);
        block_start   = bs;
        bus.pix_valid = pv;
        bus.pix_data  = pd[PIX-1:0];
        @(posedge clk);
        e_wv   = 1'b0;
        e_done = 1'b0;
        if (bs) begin
            if (m_busy || pv) m_err = 1'b1;
            if (s3_enable && s3_block > 3'd5) m_err = 1'b1;
            m_s4   = {s3_mv_h, s3_mv_v, s3_mb_x, s3_mb_y, s3_mb_intra,
                      s3_block, s3_coded, s3_enable};
            m_blk  = int'(s3_block);
            m_mbx  = int'(s3_mb_x);
            m_mby  = int'(s3_mb_y);
            m_busy = s3_enable && (s3_block <= 3'd5);
            m_cnt  = 0;
        end else if (pv) begin
            if (m_busy) begin
                e_wv    = 1'b1;
                e_plane = ref_plane(m_blk);
                e_x     = ref_x(m_blk, m_mbx, m_cnt);
                e_y     = ref_y(m_blk, m_mby, m_cnt);
                e_data  = pd % 256;
                m_cnt++;
                if (m_cnt == 64) begin
                    m_cnt  = 0;
                    m_busy = 1'b0;
                    e_done = 1'b1;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
        block_start   = 1'b0;
        bus.pix_valid = 1'b0;
        if (bus.wr_valid === 1'b1) n_writes++;
        check_outputs();
    endtask

    // Reset is asynchronous: outputs must be cleared before any clock edge.
    task automatic do_reset();
        block_start   = 1'b0;
        bus.pix_valid = 1'b0;
        reset = 1'b1;
        #2;
        m_busy = 0; m_err = 0; e_wv = 0; e_done = 0; m_cnt = 0;
        m_blk = 0; m_mbx = 0; m_mby = 0; m_s4 = '0;
        e_plane = 0; e_x = 0; e_y = 0; e_data = 0;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic gaps(input int gmin, input int gmax);
        repeat ($urandom_range(gmax, gmin)) step(1'b0, 1'b0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2, 1, 3, 0, 40, 24, 47, 31, 0, 0};
        vecs[1] = '{1, 0, 5, 2, 8, 0, 15, 7, 1, 3};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 7, 7, 0, 2};
        vecs[3] = '{63, 31, 3, 0, 1016, 504, 1023, 511, 0, 1};
        vecs[4] = '{5, 3, 4, 1, 40, 24, 47, 31, 0, 2};
        vecs[5] = '{10, 7, 2, 0, 160, 120, 167, 127, 0, 1};
        vecs[6] = '{7, 2, 1, 0, 120, 32, 127, 39, 1, 2};

        #1;
        do_reset();

        // Geometry table: full blocks, first/last write positions and done pulse
        for (int i = 0; i < 7; i++) begin
            set_s3(vecs[i].mbx, vecs[i].mby, vecs[i].blk, 1'b1);
            step(1'b1, 1'b0, 0);
            for (int k = 0; k < 64; k++) begin
                gaps(vecs[i].gmin, vecs[i].gmax);
                step(1'b0, 1'b1, (i == 0) ? k : int'($urandom_range(255, 0)));
                if (k == 0) begin
                    chk("vec_first_plane", longint'(bus.wr_plane), longint'(vecs[i].plane));
                    chk("vec_first_x", longint'(bus.wr_x), longint'(vecs[i].x0));
                    chk("vec_first_y", longint'(bus.wr_y), longint'(vecs[i].y0));
                end
                if (k == 63) begin
                    chk("vec_last_x", longint'(bus.wr_x), longint'(vecs[i].x63));
                    chk("vec_last_y", longint'(bus.wr_y), longint'(vecs[i].y63));
                    chk("vec_done", longint'(bus.block_done), 64'd1);
                end
            end
            step(1'b0, 1'b0, 0);
            chk("vec_busy_after", longint'(busy), 64'd0);
            chk("vec_err_after", longint'(err), 64'd0);
        end

        // Disabled block: pixels are not written and flag an error
        do_reset();
        set_s3(4, 4, 0, 1'b0);
        step(1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, k);
            chk("dis_no_write", longint'(bus.wr_valid), 64'd0);
        end
        chk("dis_err", longint'(err), 64'd1);

        // Early block_start restarts the counter at the new block origin
        do_reset();
        set_s3(1, 1, 0, 1'b1);
        step(1'b1, 1'b0, 0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, k);
        set_s3(2, 2, 1, 1'b1);
        step(1'b1, 1'b0, 0);
        chk("early_mbx", longint'(s4_mb_x), 64'd2);
        step(1'b0, 1'b1, 55);
        chk("early_x", longint'(bus.wr_x), 64'd40);
        chk("early_y", longint'(bus.wr_y), 64'd32);
        chk("early_err", longint'(err), 64'd1);

        // Pixel coincident with block_start is dropped
        do_reset();
        set_s3(3, 1, 0, 1'b1);
        step(1'b1, 1'b1, 99);
        chk("coinc_no_write", longint'(bus.wr_valid), 64'd0);
        chk("coinc_err", longint'(err), 64'd1);
        step(1'b0, 1'b1, 7);
        chk("coinc_next_valid", longint'(bus.wr_valid), 64'd1);
        chk("coinc_next_x", longint'(bus.wr_x), 64'd48);
        chk("coinc_next_y", longint'(bus.wr_y), 64'd16);

        // Block numbers 6-7 with enable set are rejected
        do_reset();
        set_s3(1, 1, 6, 1'b1);
        step(1'b1, 1'b0, 0);
        chk("blk6_err", longint'(err), 64'd1);
        chk("blk6_busy", longint'(busy), 64'd0);
        step(1'b0, 1'b1, 3);
        chk("blk6_no_write", longint'(bus.wr_valid), 64'd0);

        // Reset mid-block, then a full block yields exactly 64 writes
        do_reset();
        set_s3(0, 2, 2, 1'b1);
        step(1'b1, 1'b0, 0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, k);
        do_reset();
        n_writes = 0;
        set_s3(3, 3, 4, 1'b1);
        step(1'b1, 1'b0, 0);
        for (int k = 0; k < 64; k++) begin
            gaps(0, 1);
            step(1'b0, 1'b1, int'($urandom_range(255, 0)));
        end
        repeat (3) step(1'b0, 1'b0, 0);
        chk("rst_full_writes", longint'(n_writes), 64'd64);
        chk("rst_full_err", longint'(err), 64'd0);

        // Randomized traffic, including truncated/overlong blocks and bad block ids
        do_reset();
        for (int b = 0; b < 25; b++) begin
            int npix;
            set_s3(int'($urandom_range(63, 0)), int'($urandom_range(31, 0)),
                   int'($urandom_range(7, 0)), ($urandom_range(3, 0) != 0));
            step(1'b1, ($urandom_range(7, 0) == 0), int'($urandom_range(255, 0)));
            npix = ($urandom_range(1, 0) != 0) ? 64 : int'($urandom_range(70, 0));
            for (int k = 0; k < npix; k++) begin
                gaps(0, 2);
                step(1'b0, 1'b1, int'($urandom_range(255, 0)));
            end
            gaps(0, 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
